cc_pin_conditioner: RTL
=======================

CC_PIN_CONDITIONER -- requirements
Module: cc_pin_conditioner

Interface
REQ-001 Parameter NUM_CH, default 2, number of CC input channels; legal range 1..8.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel; legal values >= 2.
REQ-003 Parameter FILT_LEN, default 2, consecutive differing samples needed to accept a new level; legal values >= 1, where 1 means no filtering.
REQ-004 Parameter IDLE_CYC, default 2700 (100 us at 27 MHz), cycles without a filtered edge before a channel counts as idle; legal values >= 1.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-007 cc_pin  input  NUM_CH  raw asynchronous CC pin levels, bit i = channel i.
REQ-008 cc_filt  output  NUM_CH  synchronized, deglitched level per channel.
REQ-009 cc_act  output  NUM_CH  per-channel activity flag.
REQ-010 sel_vld  output  1  a channel is currently selected.
REQ-011 sel_ch  output  max(1,$clog2(NUM_CH))  index of the selected channel.
REQ-012 cc_out  output  1  filtered level of the selected channel, to the BMC decoder.

Function
REQ-013 Each channel SHALL pass cc_pin[i] through SYNC_STAGES flops; the final stage is s[i].
REQ-014 Per channel: if s[i]==cc_filt[i], filter count <= 0; else if count==FILT_LEN-1, cc_filt[i] <= s[i] and count <= 0; else count increments.
REQ-015 Latency from a stable cc_pin change to cc_filt SHALL be exactly SYNC_STAGES+FILT_LEN clock edges.
REQ-016 A differing run shorter than FILT_LEN samples SHALL leave cc_filt unchanged.
REQ-017 A filtered edge on channel i (cc_filt[i] changes) SHALL load idle timer i with IDLE_CYC; otherwise a nonzero timer decrements by 1 per cycle; cc_act[i] = (timer i != 0), registered.
REQ-018 Selection FSM states: FREE (sel_vld=0) and LOCK (sel_vld=1).
REQ-019 FREE -> LOCK on the cycle any channel has a filtered edge; sel_ch <= lowest-indexed channel with an edge that cycle; simultaneous edges -> lowest index wins.
REQ-020 LOCK -> FREE when timer[sel_ch] reaches 0; sel_ch holds its last value while in FREE.
REQ-021 In LOCK, edges on non-selected channels SHALL NOT change sel_ch.
REQ-022 On release, the FSM SHALL enter FREE for at least one cycle and re-lock only on a new edge, even if other channels are still active.
REQ-023 cc_out SHALL be cc_filt[sel_ch] when sel_vld=1, else 0; it is combinational from registered state, with no added latency.
REQ-024 With NUM_CH=1, sel_ch SHALL be constant 0.

Reset
REQ-025 When rst_n=0 at posedge clk, all synchronizer flops, filter counts, cc_filt, idle timers, cc_act, sel_vld, sel_ch and (if compiled in) glitch counters SHALL clear to 0.
REQ-026 Reset asserted mid-filter or mid-lock SHALL abort the operation with no residual state; the first sample is taken on the first edge with rst_n=1.

Configuration
REQ-027 Macro CC_GLITCH_CNT_EN, when defined, SHALL add an output glitch_cnt of width NUM_CH*16, with one 16-bit saturating counter per channel.
REQ-028 With CC_GLITCH_CNT_EN defined, channel i's counter SHALL increment when s[i]==cc_filt[i] while its filter count is nonzero (a rejected glitch), and saturate at 0xFFFF.
REQ-029 Without CC_GLITCH_CNT_EN, the glitch_cnt port and its counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Defaults, cc_pin=2'b01 held from cycle 10 -> cc_filt[0] rises at cycle 14; sel_vld=1, sel_ch=0, cc_out=1 at cycle 14.
REQ-031 FILT_LEN=3, 2-cycle high pulse on cc_pin[1] -> cc_filt stays 0, sel_vld stays 0; glitch_cnt[31:16]=1 if CC_GLITCH_CNT_EN is defined.
REQ-032 Both channels toggle on the same cycle from FREE -> sel_ch=0; later edges on ch1 while ch0 is active -> sel_ch remains 0.
REQ-033 IDLE_CYC=10, single edge on ch0 then silence -> cc_act[0] and sel_vld drop exactly 10 cycles after the edge; the next ch1 edge -> sel_ch=1.
REQ-034 rst_n low for 1 cycle while locked with cc_pin=2'b11 -> all outputs 0 the next cycle; cc_filt returns to 2'b11 SYNC_STAGES+FILT_LEN edges after rst_n=1.
REQ-035 With CC_GLITCH_CNT_EN, 70000 single-cycle glitches on ch0 -> glitch_cnt[15:0]=0xFFFF, with no wrap.

Source files
------------

// File: rtl/cc_pin_conditioner.sv
// rtl/cc_pin_conditioner.sv - CC pin synchronizer, deglitch filter, idle tracking and channel select
// Optional per-channel glitch counters compiled in with CC_GLITCH_CNT_EN.
module cc_pin_conditioner #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int IDLE_CYC    = 2700
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CH-1:0]                            cc_pin,
  output logic [NUM_CH-1:0]                            cc_filt,
  output logic [NUM_CH-1:0]                            cc_act,
  output logic                                         sel_vld,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_ch,
  output logic                                         cc_out
`ifdef CC_GLITCH_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]                         glitch_cnt
`endif
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(IDLE_CYC + 1);

  typedef enum logic {ST_FREE = 1'b0, ST_LOCK = 1'b1} state_t;

  logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]     r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_filt;
  logic [TW-1:0]     r_tmr  [NUM_CH];
  logic [NUM_CH-1:0] r_act;
  state_t            r_state;
  logic              r_sel_vld;
  logic [SW-1:0]     r_sel_ch;

  logic [NUM_CH-1:0] w_s;
  logic [NUM_CH-1:0] w_edge;
  logic [TW-1:0]     w_tmr_nxt [NUM_CH];
  logic [SW-1:0]     w_low;
  logic              w_sel_idle;
  logic              w_sel_filt;

  assign w_s = r_sync[SYNC_STAGES-1];

  // A filtered edge is the cycle the filter accepts a new level.
  always_comb begin
    w_edge = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_edge[i] = (w_s[i] != r_filt[i]) && (r_cnt[i] == CW'(FILT_LEN - 1));
      if (w_edge[i])
        w_tmr_nxt[i] = TW'(IDLE_CYC);
      else if (r_tmr[i] != '0)
        w_tmr_nxt[i] = r_tmr[i] - TW'(1);
      else
        w_tmr_nxt[i] = '0;
    end
  end

  always_comb begin
    w_low = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_edge[i])
        w_low = SW'(i);
    end
  end

  always_comb begin
    w_sel_idle = 1'b0;
    w_sel_filt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel_ch == SW'(i)) begin
        w_sel_idle = (w_tmr_nxt[i] == '0);
        w_sel_filt = r_filt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        r_sync[k] <= '0;
    end else begin
      r_sync[0] <= cc_pin;
      for (int k = 1; k < SYNC_STAGES; k++)
        r_sync[k] <= r_sync[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt <= '0;
      r_act  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_tmr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_s[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILT_LEN - 1)) begin
          r_filt[i] <= w_s[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
        r_tmr[i] <= w_tmr_nxt[i];
        r_act[i] <= (w_tmr_nxt[i] != '0);
      end
    end
  end

  // Release always passes through FREE; only a fresh edge can re-lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FREE;
      r_sel_vld <= 1'b0;
      r_sel_ch  <= '0;
    end else begin
      case (r_state)
        ST_FREE: begin
          if (|w_edge) begin
            r_state   <= ST_LOCK;
            r_sel_vld <= 1'b1;
            r_sel_ch  <= w_low;
          end
        end
        ST_LOCK: begin
          if (w_sel_idle) begin
            r_state   <= ST_FREE;
            r_sel_vld <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_FREE;
          r_sel_vld <= 1'b0;
        end
      endcase
    end
  end

`ifdef CC_GLITCH_CNT_EN
  logic [15:0] r_gcnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++)
        r_gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((w_s[i] == r_filt[i]) && (r_cnt[i] != '0) && (r_gcnt[i] != 16'hFFFF))
          r_gcnt[i] <= r_gcnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    glitch_cnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      glitch_cnt[i*16 +: 16] = r_gcnt[i];
  end
`endif

  assign cc_filt = r_filt;
  assign cc_act  = r_act;
  assign sel_vld = r_sel_vld;
  assign sel_ch  = r_sel_ch;
  assign cc_out  = r_sel_vld & w_sel_filt;

endmodule
